// File: rtl/alu_seq_muldiv.sv
// Registered ALU with valid/ready handshake: single-cycle add/sub/logic plus
// multi-cycle shift-add multiply and restoring divide sharing one accumulator.
module alu_seq_muldiv #(
  parameter int BITS = 32,
  localparam int CNT_W = $clog2(BITS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      S,
  input  logic [BITS-1:0] A,
  input  logic [BITS-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] Y,
  output logic [3:0]      NZCV,
  output logic            busy
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_OR  = 4'b1001;
  localparam logic [3:0] OP_XOR = 4'b1010;
  localparam logic [3:0] OP_NOR = 4'b1011;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [1:0]        op_reg;
  logic [BITS-1:0]   opnd_reg;
  logic [2*BITS-1:0] acc_reg;
  logic [BITS-1:0]   y_reg;
  logic [3:0]        nzcv_reg;
  logic              out_valid_reg;

  logic accept;
  logic long_op;

  assign in_ready  = !rst && (state_reg == IDLE) && (!out_valid_reg || out_ready);
  assign accept    = in_valid && in_ready;
  assign long_op   = (S[3:2] == 2'b01);
  assign busy      = (state_reg == BUSY);
  assign out_valid = out_valid_reg;
  assign Y         = y_reg;
  assign NZCV      = nzcv_reg;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept && long_op) state_next = BUSY;
      BUSY:    if (cnt_reg == CNT_W'(BITS - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Single-cycle operations
  logic [BITS-1:0] b_eff;
  logic [BITS:0]   add_sum;
  logic [BITS-1:0] alu_y;
  logic            alu_c;
  logic            alu_v;

  always_comb begin
    b_eff   = S[0] ? ~B : B;
    add_sum = {1'b0, A} + {1'b0, b_eff} + {{BITS{1'b0}}, S[0]};
    alu_y   = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (S)
      OP_ADD, OP_SUB: begin
        alu_y = add_sum[BITS-1:0];
        alu_c = add_sum[BITS];
        alu_v = (A[BITS-1] == b_eff[BITS-1]) && (alu_y[BITS-1] != A[BITS-1]);
      end
      OP_AND:  alu_y = A & B;
      OP_OR:   alu_y = A | B;
      OP_XOR:  alu_y = A ^ B;
      OP_NOR:  alu_y = ~(A | B);
      default: alu_y = '0;
    endcase
  end

  // One iteration step. Multiply keeps the multiplier in the low half and
  // shifts the running sum in from the top; divide keeps the remainder in the
  // high half and shifts dividend bits out / quotient bits in at the bottom.
  logic [BITS:0]     mul_sum;
  logic [BITS:0]     div_trial;
  logic [BITS:0]     div_diff;
  logic              div_ge;
  logic [2*BITS-1:0] acc_step;

  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*BITS-1:BITS]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    div_trial = {acc_reg[2*BITS-1:BITS], acc_reg[BITS-1]};
    div_diff  = div_trial - {1'b0, opnd_reg};
    div_ge    = !div_diff[BITS];
    if (!op_reg[1]) begin
      acc_step = {mul_sum, acc_reg[BITS-1:1]};
    end else begin
      acc_step = {(div_ge ? div_diff[BITS-1:0] : div_trial[BITS-1:0]),
                  acc_reg[BITS-2:0], div_ge};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg  <= '0;
      op_reg   <= '0;
      opnd_reg <= '0;
      acc_reg  <= '0;
    end else if (accept && long_op) begin
      cnt_reg <= '0;
      op_reg  <= S[1:0];
      if (S[1]) begin
        opnd_reg <= B;
        acc_reg  <= {{BITS{1'b0}}, A};
      end else begin
        opnd_reg <= A;
        acc_reg  <= {{BITS{1'b0}}, B};
      end
    end else if (state_reg == BUSY) begin
      acc_reg <= acc_step;
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Final result of a multi-cycle op, taken from the accumulator in DONE
  logic [BITS-1:0] done_y;
  logic            done_v;

  always_comb begin
    done_y = '0;
    done_v = 1'b0;
    case (op_reg)
      2'b00: begin
        done_y = acc_reg[BITS-1:0];
        done_v = |acc_reg[2*BITS-1:BITS];
      end
      2'b01: done_y = acc_reg[2*BITS-1:BITS];
      2'b10: begin
        done_y = acc_reg[BITS-1:0];
        done_v = (opnd_reg == '0);
      end
      default: begin
        done_y = acc_reg[2*BITS-1:BITS];
        done_v = (opnd_reg == '0);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_reg         <= '0;
      nzcv_reg      <= '0;
      out_valid_reg <= 1'b0;
    end else if (accept && !long_op) begin
      y_reg         <= alu_y;
      nzcv_reg      <= {alu_y[BITS-1], (alu_y == '0), alu_c, alu_v};
      out_valid_reg <= 1'b1;
    end else if (state_reg == DONE) begin
      y_reg         <= done_y;
      nzcv_reg      <= {done_y[BITS-1], (done_y == '0), 1'b0, done_v};
      out_valid_reg <= 1'b1;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

endmodule
